// File: rtl/inst_fetch_mod.sv
// Instruction fetch stage: reads opcode bytes at pc (folding the CB prefix into opcode bit 8) and immediates.
// Optional one-byte prefetch buffer, enabled by defining INST_FETCH_PREFETCH_EN.
`timescale 1ns/1ps
module inst_fetch_mod #(
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        fetch_next,
    input  logic        imm_req,
    input  logic        imm_len,
    input  logic        pc_load,
    input  logic [15:0] pc_load_value,
    output logic [8:0]  opcode,
    output logic        opcode_valid,
    output logic [15:0] imm,
    output logic        imm_valid,
    output logic [15:0] pc
);

    typedef enum logic [2:0] {
        FETCH_OP,
        FETCH_CB,
        READY,
        FETCH_IMM_LO,
        FETCH_IMM_HI
    } state_t;

    state_t      state;
    logic [15:0] pc_q;
    logic        bus_take;
    logic        byte_ok;
    logic [7:0]  byte_in;
    logic        ready_hold;
    logic        ready_req;

    assign bus_take = mem_req & mem_ack;
    assign mem_addr = pc_q;

`ifdef INST_FETCH_PREFETCH_EN
    logic [7:0] pf_data;
    logic       pf_valid;

    assign byte_ok    = pf_valid | bus_take;
    assign byte_in    = pf_valid ? pf_data : mem_rdata;
    assign pc         = pc_q - {15'd0, pf_valid};
    // A READY read still outstanding is carried into the next fetch so its byte is used directly.
    assign ready_hold = mem_req & ~mem_ack;
    assign ready_req  = ready_hold | (~mem_req & ~pf_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_data  <= 8'h00;
        end else if (pc_load) begin
            pf_valid <= 1'b0;
        end else if (state == READY && bus_take) begin
            pf_data  <= mem_rdata;
            pf_valid <= 1'b1;
        end else if (state == FETCH_OP || state == FETCH_IMM_LO) begin
            pf_valid <= 1'b0;
        end
    end
`else
    assign byte_ok    = bus_take;
    assign byte_in    = mem_rdata;
    assign pc         = pc_q;
    assign ready_hold = 1'b0;
    assign ready_req  = 1'b0;
`endif

    // NOTE: every register here is assigned with <= so all branches see the pre-edge values of state and pc_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= FETCH_OP;
            pc_q         <= PC_RESET;
            opcode       <= 9'h000;
            opcode_valid <= 1'b0;
            imm          <= 16'h0000;
            imm_valid    <= 1'b0;
            mem_req      <= 1'b0;
        end else if (pc_load) begin
            // Any coinciding ack is dropped; mem_req idles one cycle before reading at the new pc.
            state        <= FETCH_OP;
            pc_q         <= pc_load_value;
            opcode_valid <= 1'b0;
            imm_valid    <= 1'b0;
            mem_req      <= 1'b0;
        end else begin
            if (bus_take) begin
                pc_q <= pc_q + 16'd1;
            end
            case (state)
                FETCH_OP: begin
                    mem_req <= 1'b1;
                    if (byte_ok) begin
                        if (byte_in == CB_PREFIX) begin
                            state <= FETCH_CB;
                        end else begin
                            opcode       <= {1'b0, byte_in};
                            opcode_valid <= 1'b1;
                            mem_req      <= 1'b0;
                            state        <= READY;
                        end
                    end
                end
                FETCH_CB: begin
                    mem_req <= 1'b1;
                    if (byte_ok) begin
                        opcode       <= {1'b1, byte_in};
                        opcode_valid <= 1'b1;
                        mem_req      <= 1'b0;
                        state        <= READY;
                    end
                end
                READY: begin
                    if (fetch_next) begin
                        opcode_valid <= 1'b0;
                        imm_valid    <= 1'b0;
                        mem_req      <= ready_hold;
                        state        <= FETCH_OP;
                    end else if (imm_req) begin
                        imm_valid <= 1'b0;
                        mem_req   <= ready_hold;
                        state     <= FETCH_IMM_LO;
                    end else begin
                        mem_req <= ready_req;
                    end
                end
                FETCH_IMM_LO: begin
                    mem_req <= 1'b1;
                    if (byte_ok) begin
                        imm[7:0] <= byte_in;
                        if (!imm_len) begin
                            imm[15:8] <= 8'h00;
                            imm_valid <= 1'b1;
                            mem_req   <= 1'b0;
                            state     <= READY;
                        end else begin
                            state <= FETCH_IMM_HI;
                        end
                    end
                end
                FETCH_IMM_HI: begin
                    mem_req <= 1'b1;
                    if (byte_ok) begin
                        imm[15:8] <= byte_in;
                        imm_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= READY;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= FETCH_OP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_mod.sv
// Directed bench for inst_fetch_mod: byte-addressed memory responder with programmable wait states,
// expected opcodes/immediates queued at stimulus time and compared when the matching valid rises.
`timescale 1ns/1ps
module tb_inst_fetch_mod;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        fetch_next;
    logic        imm_req;
    logic        imm_len;
    logic        pc_load;
    logic [15:0] pc_load_value;
    logic [8:0]  opcode;
    logic        opcode_valid;
    logic [15:0] imm;
    logic        imm_valid;
    logic [15:0] pc;

    int          vectors     = 0;
    int          miscompares = 0;
    int          wait_cycles = 0;
    int          wcnt        = 0;
    logic        stray_ack   = 1'b0;
    logic [7:0]  mem [0:65535];
    logic [15:0] sb_q [$];

    always #5 clock = ~clock;

    inst_fetch_mod #(
        .PC_RESET (16'h0100),
        .CB_PREFIX(8'hCB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .fetch_next   (fetch_next),
        .imm_req      (imm_req),
        .imm_len      (imm_len),
        .pc_load      (pc_load),
        .pc_load_value(pc_load_value),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .imm          (imm),
        .imm_valid    (imm_valid),
        .pc           (pc)
    );

    // Memory responder: acks after wait_cycles idle request cycles, driven on the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hEE;
        forever begin
            @(negedge clock);
            if (mem_req) begin
                if (wcnt >= wait_cycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt      = 0;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 8'hEE;
                    wcnt      = wcnt + 1;
                end
            end else begin
                mem_ack   = stray_ack;
                mem_rdata = 8'hEE;
                wcnt      = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for opcode_valid or imm_valid, then compare against the oldest queued expectation.
    task automatic await_out(input string tag, input logic want_imm, input int exp_lat);
        int          edges = 0;
        logic [15:0] e;
        while (edges < 20) begin
            @(posedge clock);
            #1;
            edges++;
            if (want_imm ? imm_valid : opcode_valid) break;
        end
        check({tag, " valid"}, 16'(want_imm ? imm_valid : opcode_valid), 16'h0001);
        check({tag, " latency"}, 16'(edges), 16'(exp_lat));
        check({tag, " pending"}, 16'(sb_q.size()), 16'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " data"}, want_imm ? imm : 16'(opcode), e);
        end
    endtask

    task automatic do_fetch(input string tag, input logic [8:0] exp_op, input int exp_lat);
        sb_q.push_back(16'(exp_op));
        fetch_next = 1'b1;
        @(posedge clock);
        #1;
        fetch_next = 1'b0;
        check({tag, " ov clr"}, 16'(opcode_valid), 16'h0000);
        await_out(tag, 1'b0, exp_lat);
    endtask

    task automatic do_imm(input string tag, input logic len, input logic [15:0] exp_imm, input int exp_lat);
        sb_q.push_back(exp_imm);
        imm_len = len;
        imm_req = 1'b1;
        @(posedge clock);
        #1;
        imm_req = 1'b0;
        check({tag, " iv clr"}, 16'(imm_valid), 16'h0000);
        check({tag, " ov held"}, 16'(opcode_valid), 16'h0001);
        await_out(tag, 1'b1, exp_lat);
    endtask

    task automatic do_load(input string tag, input logic [15:0] addr, input logic [8:0] exp_op, input int exp_lat);
        sb_q.push_back(16'(exp_op));
        pc_load       = 1'b1;
        pc_load_value = addr;
        @(posedge clock);
        #1;
        pc_load = 1'b0;
        check({tag, " pc load"}, pc, addr);
        check({tag, " req gap"}, 16'(mem_req), 16'h0000);
        check({tag, " ov clr"}, 16'(opcode_valid), 16'h0000);
        await_out(tag, 1'b0, exp_lat);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
        mem[16'h0202] = 8'hCB; mem[16'h0203] = 8'hCB;
        mem[16'h0204] = 8'h21; mem[16'h0205] = 8'h34; mem[16'h0206] = 8'h12;
        mem[16'h0207] = 8'h3E; mem[16'h0208] = 8'hFE;
        mem[16'h0209] = 8'hCB; mem[16'h020A] = 8'h45;
        mem[16'h020B] = 8'hAA; mem[16'h020C] = 8'hBB;
        mem[16'h4000] = 8'h5A; mem[16'hFFFF] = 8'h77;
        mem[16'h0000] = 8'h66; mem[16'h0001] = 8'h10;

        reset = 1'b1; fetch_next = 1'b0; imm_req = 1'b0; imm_len = 1'b0;
        pc_load = 1'b0; pc_load_value = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check("rst pc", pc, 16'h0100);
        check("rst opcode", 16'(opcode), 16'h0000);
        check("rst imm", imm, 16'h0000);
        check("rst ov", 16'(opcode_valid), 16'h0000);
        check("rst iv", 16'(imm_valid), 16'h0000);
        check("rst req", 16'(mem_req), 16'h0000);

        // First opcode after reset: request rises at edge 1, opcode valid at edge 2.
        sb_q.push_back(16'h0000);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("boot req", 16'(mem_req), 16'h0001);
        check("boot addr", mem_addr, 16'h0100);
        check("boot ov early", 16'(opcode_valid), 16'h0000);
        await_out("boot op", 1'b0, 1);
        check("boot pc", pc, 16'h0101);

        do_load("cb op", 16'h0200, 9'h137, 3);
        check("cb pc", pc, 16'h0202);
        do_fetch("cb cb", 9'h1CB, 3);
        check("cbcb pc", pc, 16'h0204);
        do_fetch("op21", 9'h021, 2);
        check("op21 pc", pc, 16'h0205);
        do_imm("imm16", 1'b1, 16'h1234, 3);
        check("imm16 pc", pc, 16'h0207);
        check("imm16 op held", 16'(opcode), 16'h0021);
        do_fetch("op3e", 9'h03E, 2);
        check("op3e pc", pc, 16'h0208);
        do_imm("imm8", 1'b0, 16'h00FE, 2);
        check("imm8 pc", pc, 16'h0209);

        // Two wait cycles per byte: address held while requesting, pc moves only on the ack edge.
        wait_cycles = 2;
        sb_q.push_back(16'h0145);
        fetch_next = 1'b1;
        @(posedge clock);
        #1;
        fetch_next = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            check("wait req", 16'(mem_req), 16'h0001);
            check("wait addr", mem_addr, (k <= 3) ? 16'h0209 : 16'h020A);
            check("wait pc", pc, (k <= 3) ? 16'h0209 : 16'h020A);
            check("wait ov", 16'(opcode_valid), 16'h0000);
        end
        await_out("wait op", 1'b0, 1);
        check("wait end pc", pc, 16'h020B);
        wait_cycles = 0;

        // pc_load lands in FETCH_IMM_HI together with the high-byte ack.
        imm_len = 1'b1;
        imm_req = 1'b1;
        @(posedge clock);
        #1;
        imm_req = 1'b0;
        @(posedge clock);
        #1;
        check("ld lo req", 16'(mem_req), 16'h0001);
        check("ld lo addr", mem_addr, 16'h020B);
        @(posedge clock);
        #1;
        check("ld hi pc", pc, 16'h020C);
        check("ld hi req", 16'(mem_req), 16'h0001);
        pc_load       = 1'b1;
        pc_load_value = 16'h4000;
        sb_q.push_back(16'h005A);
        @(posedge clock);
        #1;
        pc_load = 1'b0;
        check("ld pc", pc, 16'h4000);
        check("ld gap", 16'(mem_req), 16'h0000);
        check("ld iv", 16'(imm_valid), 16'h0000);
        check("ld ov", 16'(opcode_valid), 16'h0000);
        @(posedge clock);
        #1;
        check("ld new req", 16'(mem_req), 16'h0001);
        check("ld new addr", mem_addr, 16'h4000);
        await_out("ld op", 1'b0, 1);
        check("ld end pc", pc, 16'h4001);
        check("ld end iv", 16'(imm_valid), 16'h0000);

        // Acks without a request are ignored.
        stray_ack = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        stray_ack = 1'b0;
        check("stray pc", pc, 16'h4001);
        check("stray req", 16'(mem_req), 16'h0000);
        check("stray ov", 16'(opcode_valid), 16'h0001);
        check("stray op", 16'(opcode), 16'h005A);

        do_load("wrap", 16'hFFFF, 9'h077, 2);
        check("wrap pc", pc, 16'h0000);
        do_imm("imm wrap", 1'b0, 16'h0066, 2);
        check("imm wrap pc", pc, 16'h0001);

        // fetch_next beats a simultaneous imm_req.
        sb_q.push_back(16'h0010);
        fetch_next = 1'b1;
        imm_req    = 1'b1;
        imm_len    = 1'b1;
        @(posedge clock);
        #1;
        fetch_next = 1'b0;
        imm_req    = 1'b0;
        check("prio iv", 16'(imm_valid), 16'h0000);
        check("prio ov", 16'(opcode_valid), 16'h0000);
        await_out("prio op", 1'b0, 2);
        check("prio pc", pc, 16'h0002);
        check("prio iv end", 16'(imm_valid), 16'h0000);
        check("prio imm", imm, 16'h0066);

        // Asynchronous reset while a read is waiting on the bus.
        wait_cycles = 2;
        fetch_next  = 1'b1;
        @(posedge clock);
        #1;
        fetch_next = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("mid rst req", 16'(mem_req), 16'h0000);
        check("mid rst pc", pc, 16'h0100);
        check("mid rst ov", 16'(opcode_valid), 16'h0000);
        check("mid rst op", 16'(opcode), 16'h0000);
        check("mid rst imm", imm, 16'h0000);
        check("mid rst iv", 16'(imm_valid), 16'h0000);
        wait_cycles = 0;
        sb_q.push_back(16'h0000);
        @(negedge clock);
        reset = 1'b0;
        await_out("reboot op", 1'b0, 2);
        check("reboot pc", pc, 16'h0101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
